ifetch_unit: RTL and testbench

- Fetch-side consumer of the PC register. Takes current_pc and issues it as an instruction-memory request over a valid/ready handshake.
- Returns next_pc and pc_stall to the PC register.
- Queues in-order memory responses, each paired with its issuing PC, in a small buffer that feeds the decode stage.
- Handles redirects (branch/jump/exception) by flushing buffered instructions and discarding in-flight responses.

---
 rtl/ifetch_unit.sv | 174 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues current_pc to imem, steers the PC register, buffers in-order responses for decode.
// Latency: request combinational from current_pc; response visible to decode one cycle after it returns.
// Backpressure: requests gated by credit (outstanding + buffered < BUF_DEPTH); decode stalls hold the buffer.

// Small synchronous FIFO with flush; head read straight from storage, so outputs are registered.
module ifetch_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Next pointers and occupancy; a flush empties the queue regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer/count registers and storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end
endmodule

module ifetch_unit #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] current_pc,
  output logic [31:0] next_pc,
  output logic        pc_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] kill_q, kill_d;
  logic [CW-1:0] instr_cnt, pend_cnt;
  logic [CW:0]   inflight;
  logic          credit, req_vld, fire;
  logic          rsp_acc, rsp_keep;
  logic [31:0]   pend_head;
  logic [63:0]   instr_head;

  // Credit uses registered counts only, so a decode pop this cycle frees space next cycle.
  assign inflight       = {1'b0, outst_q} + {1'b0, instr_cnt};
  assign credit         = inflight < (CW+1)'(BUF_DEPTH);
  assign req_vld        = rst_n && credit && !redirect_valid;
  assign fire           = req_vld && imem_req_ready;
  assign imem_req_valid = req_vld;
  assign imem_req_addr  = {current_pc[31:2], 2'b00};

  // Both trackers agree in normal operation; requiring both keeps a stray response from corrupting either.
  assign rsp_acc  = imem_rsp_valid && (outst_q != '0) && (pend_cnt != '0);
  assign rsp_keep = rsp_acc && !redirect_valid && (kill_q == '0);

  assign id_valid = (instr_cnt != '0);
  assign id_instr = instr_head[63:32];
  assign id_pc    = instr_head[31:0];

  // PC register steering: redirect beats sequential advance; no accepted request means hold.
  always_comb begin
    next_pc  = current_pc + 32'(PC_STEP);
    pc_stall = 1'b0;
    if (rst_n) begin
      if (redirect_valid) begin
        next_pc = redirect_pc;
      end else if (!fire) begin
        next_pc  = current_pc;
        pc_stall = 1'b1;
      end
    end
  end

  // Outstanding tracks accepted minus returned; kill covers whatever is still in flight after a redirect.
  always_comb begin
    outst_d = outst_q;
    if (fire && !rsp_acc)      outst_d = outst_q + 1'b1;
    else if (!fire && rsp_acc) outst_d = outst_q - 1'b1;
    kill_d = kill_q;
    if (redirect_valid)                  kill_d = rsp_acc ? (outst_q - 1'b1) : outst_q;
    else if (rsp_acc && kill_q != '0)    kill_d = kill_q - 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
      kill_q  <= '0;
    end else begin
      outst_q <= outst_d;
      kill_q  <= kill_d;
    end
  end

  ifetch_fifo #(.W(32), .DEPTH(BUF_DEPTH)) u_pend_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (1'b0),
    .push_i     (fire),
    .push_dat_i (current_pc),
    .pop_i      (rsp_acc),
    .head_o     (pend_head),
    .count_o    (pend_cnt)
  );

  ifetch_fifo #(.W(64), .DEPTH(BUF_DEPTH)) u_instr_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (redirect_valid),
    .push_i     (rsp_keep),
    .push_dat_i ({imem_rsp_data, pend_head}),
    .pop_i      (id_valid && id_ready),
    .head_o     (instr_head),
    .count_o    (instr_cnt)
  );

  // A response with nothing outstanding is a memory protocol violation.
  a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outst_q != '0));
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-level reference model checked every cycle, plus directed scenarios.
// Memory model returns responses in order after a programmable latency.
// PC register is modelled in the bench and fed back from next_pc/pc_stall.
module tb_ifetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] current_pc;
  logic [31:0] next_pc;
  logic        pc_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] m_pend[$];
  logic [63:0] m_instr[$];
  int          m_kill;
  logic [31:0] deliv[$];
  int          acc_cnt;
  int          cyc = 0;
  int          mem_lat;
  logic        pc_fb;
  logic [31:0] pc_nxt;

  ifetch_unit #(.BUF_DEPTH(DEPTH), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .current_pc     (current_pc),
    .next_pc        (next_pc),
    .pc_stall       (pc_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] deliv_at(input int i);
    if (deliv.size() > i) return deliv[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Reference model: compare on the falling edge, then advance to the state after the next rising edge.
  always @(negedge clk) begin
    int          cnt, outs;
    logic        credit, e_req, fire, keep;
    logic [31:0] e_next, p;
    logic        e_stall;
    if (!rst_n) begin
      m_pend.delete();
      m_instr.delete();
      m_kill = 0;
      mq.delete();
      chk("rst_id_valid", id_valid, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_pc_stall", pc_stall, 0);
      chk("rst_next_pc", next_pc, current_pc + 32'd4);
    end else begin
      cnt    = m_instr.size();
      outs   = m_pend.size();
      credit = (outs + cnt) < DEPTH;
      e_req  = credit && !redirect_valid;
      fire   = e_req && imem_req_ready;
      if (redirect_valid) begin
        e_next = redirect_pc; e_stall = 1'b0;
      end else if (fire) begin
        e_next = current_pc + 32'd4; e_stall = 1'b0;
      end else begin
        e_next = current_pc; e_stall = 1'b1;
      end
      chk("req_valid", imem_req_valid, e_req);
      chk("req_addr", imem_req_addr, current_pc & 32'hFFFF_FFFC);
      chk("next_pc", next_pc, e_next);
      chk("pc_stall", pc_stall, e_stall);
      chk("id_valid", id_valid, cnt > 0);
      if (cnt > 0) begin
        chk("id_pc", id_pc, m_instr[0][31:0]);
        chk("id_instr", id_instr, m_instr[0][63:32]);
      end
      if (id_valid && id_ready && !redirect_valid) deliv.push_back(id_pc);

      keep = 1'b0;
      p    = '0;
      if (imem_rsp_valid) begin
        chk("rsp_has_pending", m_pend.size() > 0, 1);
        if (m_pend.size() > 0) begin
          p = m_pend.pop_front();
          if (!redirect_valid) begin
            if (m_kill > 0) m_kill--;
            else keep = 1'b1;
          end
        end
      end
      if (redirect_valid) begin
        m_instr.delete();
        m_kill = m_pend.size();
      end else begin
        if (cnt > 0 && id_ready) void'(m_instr.pop_front());
        if (keep) m_instr.push_back({imem_rsp_data, p});
      end
      if (fire) m_pend.push_back(current_pc);

      if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        acc_cnt++;
      end
    end
    pc_nxt = pc_stall ? current_pc : next_pc;
  end

  // Memory response driver and PC register feedback, just after the rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pc_fb) current_pc = pc_nxt;
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rst_n          = 1'b0;
    pc_fb          = 1'b0;
    current_pc     = pc0;
    redirect_valid = 1'b0;
    cyc_wait(2);
    deliv.delete();
    acc_cnt = 0;
    rst_n   = 1'b1;
    pc_fb   = 1'b1;
  endtask

  task automatic wait_deliv(input int n, input string name);
    int k = 0;
    while (deliv.size() < n && k < 200) begin
      cyc_wait(1);
      k++;
    end
    chk(name, deliv.size(), n);
  endtask

  initial begin
    int k;
    rst_n          = 1'b0;
    current_pc     = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    pc_fb          = 1'b0;
    pc_nxt         = '0;
    mem_lat        = 1;
    acc_cnt        = 0;
    m_kill         = 0;

    // Reset values.
    #3;
    chk("reset_id_valid", id_valid, 0);
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_pc_stall", pc_stall, 0);
    chk("reset_next_pc", next_pc, 32'h4);
    chk("reset_id_instr", id_instr, 0);
    chk("reset_id_pc", id_pc, 0);

    // Streaming from 0 with 1-cycle memory and decode always ready.
    do_reset(32'h0);
    #1;
    chk("s1_first_req", imem_req_valid, 1);
    chk("s1_first_addr", imem_req_addr, 32'h0);
    wait_deliv(4, "s1_count");
    chk("s1_pc0", deliv_at(0), 32'h0);
    chk("s1_pc1", deliv_at(1), 32'h4);
    chk("s1_pc2", deliv_at(2), 32'h8);
    chk("s1_pc3", deliv_at(3), 32'hC);

    // Decode blocked: buffer fills after two fetches and the PC holds at 0x8.
    id_ready = 1'b0;
    do_reset(32'h0);
    cyc_wait(8);
    #1;
    chk("s2_pc_held", current_pc, 32'h8);
    chk("s2_req_valid", imem_req_valid, 0);
    chk("s2_pc_stall", pc_stall, 1);
    chk("s2_req_count", acc_cnt, 2);
    chk("s2_head_pc", id_pc, 32'h0);
    id_ready = 1'b1;
    wait_deliv(3, "s2_count");
    chk("s2_pc0", deliv_at(0), 32'h0);
    chk("s2_pc1", deliv_at(1), 32'h4);
    chk("s2_pc2", deliv_at(2), 32'h8);

    // Memory not ready for three cycles at 0x10.
    imem_req_ready = 1'b0;
    do_reset(32'h10);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s3_stall", pc_stall, 1);
      chk("s3_next_hold", next_pc, 32'h10);
      cyc_wait(1);
    end
    imem_req_ready = 1'b1;
    #1;
    chk("s3_stall_release", pc_stall, 0);
    chk("s3_next_adv", next_pc, 32'h14);

    // Redirect with two fetches in flight; both responses must be discarded.
    mem_lat = 4;
    do_reset(32'h20);
    cyc_wait(2);
    #1;
    chk("s4_outstanding", acc_cnt, 2);
    chk("s4_stalled", pc_stall, 1);
    redirect_pc    = 32'h100;
    redirect_valid = 1'b1;
    #1;
    chk("s4_redir_next", next_pc, 32'h100);
    chk("s4_redir_noreq", imem_req_valid, 0);
    cyc_wait(1);
    redirect_valid = 1'b0;
    mem_lat = 1;
    k = 0;
    #1;
    while (id_valid !== 1'b1 && k < 40) begin
      cyc_wait(1);
      #1;
      k++;
    end
    chk("s4_id_seen", id_valid, 1);
    chk("s4_id_pc", id_pc, 32'h100);

    // Redirect coinciding with the response for 0x30.
    do_reset(32'h30);
    cyc_wait(1);
    redirect_pc    = 32'h200;
    redirect_valid = 1'b1;
    #1;
    chk("s5_noreq", imem_req_valid, 0);
    chk("s5_next", next_pc, 32'h200);
    chk("s5_nostall", pc_stall, 0);
    cyc_wait(1);
    redirect_valid = 1'b0;
    #1;
    chk("s5_dropped", id_valid, 0);
    wait_deliv(1, "s5_count");
    chk("s5_first_pc", deliv_at(0), 32'h200);

    // PC wrap, then asynchronous reset with one fetch outstanding.
    id_ready = 1'b0;
    do_reset(32'hFFFF_FFFC);
    #1;
    chk("s6_wrap_next", next_pc, 32'h0);
    chk("s6_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("s6_wrap_req", imem_req_valid, 1);
    cyc_wait(2);
    #1;
    chk("s6_head_valid", id_valid, 1);
    chk("s6_head_pc", id_pc, 32'hFFFF_FFFC);
    chk("s6_head_instr", id_instr, 32'h3F21_FFFC);
    rst_n = 1'b0;
    pc_fb = 1'b0;
    #1;
    chk("s6_arst_id_valid", id_valid, 0);
    chk("s6_arst_req", imem_req_valid, 0);
    chk("s6_arst_stall", pc_stall, 0);
    chk("s6_arst_id_pc", id_pc, 0);
    chk("s6_arst_id_instr", id_instr, 0);
    cyc_wait(2);
    rst_n = 1'b1;
    cyc_wait(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
